// File: rtl/imm_extend_pipe.sv
// Immediate-field extender with a 2-entry in-order output buffer.
// The result is computed combinationally from inp/mode on the input side.
// Only computed results are stored. Ready/valid handshakes are used on
// both sides. in_ready comes from registered state only, so there is no
// combinational path from out_ready to in_ready.
module imm_extend_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  inp,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] extendedOne,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    // Extend an immediate according to mode. Bits shifted above the MSB are
    // silently dropped, and vacated low bits are filled with zero.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] v,
                                                    input logic [1:0]      m);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] zext;
        logic [OUT_W-1:0] res;
        sext = {{(OUT_W-IN_W){v[IN_W-1]}}, v};
        zext = {{(OUT_W-IN_W){1'b0}}, v};
        case (m)
            2'b00:   res = sext;
            2'b01:   res = zext;
            2'b10:   res = sext << SHIFT;
            2'b11:   res = zext << SHIFT;
            default: res = {OUT_W{1'b0}};
        endcase
        return res;
    endfunction

    state_t           state_r;
    logic [OUT_W-1:0] head_r;
    logic [OUT_W-1:0] tail_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [OUT_W-1:0] result_s;
    logic             accept_s;
    logic             pop_s;

    // Input-side extension and handshake qualification.
    always_comb begin
        result_s = extend_imm(inp, mode);
        accept_s = in_valid & in_ready_r;
        pop_s    = out_valid_r & out_ready;
    end

    // Occupancy FSM with head/tail storage and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= EMPTY;
            head_r      <= {OUT_W{1'b0}};
            tail_r      <= {OUT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        head_r      <= result_s;
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept_s && !pop_s) begin
                        tail_r      <= result_s;
                        state_r     <= FULL;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else if (!accept_s && pop_s) begin
                        // An empty buffer presents all zeros at the head.
                        head_r      <= {OUT_W{1'b0}};
                        state_r     <= EMPTY;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else if (accept_s && pop_s) begin
                        head_r      <= result_s;
                        state_r     <= ONE;
                    end else begin
                        state_r     <= ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop_s) begin
                        head_r      <= tail_r;
                        state_r     <= ONE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    head_r      <= {OUT_W{1'b0}};
                    tail_r      <= {OUT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign extendedOne = head_r;

endmodule
